// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the multi-cycle load/store unit.
//   - RISC-V funct3 width/sign codes for loads and stores
//   - FSM state encoding
//   - size_bytes(): access size in bytes for a funct3 code
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Access size in bytes. The illegal code 111 falls through to 8; it is
    // rejected separately, so the value returned for it is never used.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 4'd1;
            F3_H, F3_HU: size_bytes = 4'd2;
            F3_W, F3_WU: size_bytes = 4'd4;
            default:     size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane alignment for the LSU.
//   funct3    in   access width/sign code
//   off       in   byte offset of the access within the memory word
//   wdata     in   right-justified store data
//   rdata     in   aligned memory read word
//   mask      out  byte-lane enables for the memory port
//   wdata_sh  out  store data shifted onto its byte lanes
//   misalign  out  access is misaligned or funct3 is illegal for this XLEN
//   load_data out  selected load bytes, sign- or zero-extended to XLEN
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [2:0]      funct3,
    input  logic [OFFW-1:0] off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [NB-1:0]   mask,
    output logic [XLEN-1:0] wdata_sh,
    output logic            misalign,
    output logic [XLEN-1:0] load_data
);

    logic [3:0]             sz;
    logic [OFFW-1:0]        align_m;
    logic                   illegal;
    logic [NB-1:0]          base_mask;
    logic [XLEN-1:0]        wsel;
    logic [XLEN-1:0]        rsh;
    logic signed [7:0]      b_s;
    logic signed [15:0]     h_s;
    logic signed [31:0]     w_s;
    logic                   sext;

    always_comb begin
        sz      = size_bytes(funct3);
        // Low offset bits that must be zero for a naturally aligned access.
        align_m = OFFW'(sz - 4'd1);
        illegal = (funct3 == 3'b111) ||
                  ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
        misalign = illegal || ((off & align_m) != '0);
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   base_mask = NB'(1);
            2'b01:   base_mask = NB'(3);
            2'b10:   base_mask = NB'(15);
            default: base_mask = '1;
        endcase
        mask = base_mask << off;
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   wsel = XLEN'(wdata[7:0]);
            2'b01:   wsel = XLEN'(wdata[15:0]);
            2'b10:   wsel = XLEN'(wdata[31:0]);
            default: wsel = wdata;
        endcase
        wdata_sh = wsel << {off, 3'b000};
    end

    always_comb begin
        rsh  = rdata >> {off, 3'b000};
        b_s  = rsh[7:0];
        h_s  = rsh[15:0];
        w_s  = rsh[31:0];
        // funct3[2] marks the unsigned (zero-extending) variants.
        sext = ~funct3[2];
        case (funct3[1:0])
            2'b00:   load_data = sext ? XLEN'(b_s) : XLEN'(rsh[7:0]);
            2'b01:   load_data = sext ? XLEN'(h_s) : XLEN'(rsh[15:0]);
            2'b10:   load_data = sext ? XLEN'(w_s) : XLEN'(rsh[31:0]);
            default: load_data = rsh;
        endcase
    end

endmodule

// File: rtl/lsu_multicycle.sv
// lsu_multicycle: multi-cycle load/store unit with bus-timeout watchdog.
//   clk, reset            clock, synchronous active-high reset
//   req_*                 core request (valid/ready handshake), one at a time
//   mem_*                 word-addressed memory port; mem_req held until mem_ack
//   resp_*                one-cycle response: data, rd, misalign and bus error
// Parameters: XLEN (32 or 64), TIMEOUT (1..255 cycles waiting for mem_ack).
module lsu_multicycle
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_mask,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_misalign,
    output logic              resp_buserr
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdata_out_q, rdata_out_d;
    logic [4:0]      rrd_q, rrd_d;
    logic            rmis_q, rmis_d;
    logic            rerr_q, rerr_d;

    logic [2:0]      a_f3;
    logic [OFFW-1:0] a_off;
    logic [NB-1:0]   a_mask;
    logic [XLEN-1:0] a_wdata_sh;
    logic            a_misalign;
    logic [XLEN-1:0] a_load_data;

    // In IDLE the aligner looks at the incoming request to classify it;
    // afterwards it works from the latched request so the memory port is
    // stable for the whole access.
    assign a_f3  = (state_q == IDLE) ? req_funct3 : f3_q;
    assign a_off = (state_q == IDLE) ? req_addr[OFFW-1:0] : addr_q[OFFW-1:0];

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (a_f3),
        .off       (a_off),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .mask      (a_mask),
        .wdata_sh  (a_wdata_sh),
        .misalign  (a_misalign),
        .load_data (a_load_data)
    );

    // State register. Only control state is reset; the datapath registers
    // are always written before they are observed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        we_q        <= we_d;
        f3_q        <= f3_d;
        addr_q      <= addr_d;
        wdata_q     <= wdata_d;
        rd_q        <= rd_d;
        rdata_out_q <= rdata_out_d;
        rrd_q       <= rrd_d;
        rmis_q      <= rmis_d;
        rerr_q      <= rerr_d;
    end

    // Next-state and datapath-next logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        rdata_out_d = rdata_out_q;
        rrd_d       = rrd_q;
        rmis_d      = rmis_q;
        rerr_d      = rerr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    cnt_d   = '0;
                    rerr_d  = 1'b0;
                    if (a_misalign) begin
                        state_d     = RESP;
                        rmis_d      = 1'b1;
                        rdata_out_d = '0;
                        rrd_d       = req_we ? 5'd0 : req_rd;
                    end else begin
                        state_d = ACCESS;
                        rmis_d  = 1'b0;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final timeout cycle takes priority over the error.
                if (mem_ack) begin
                    state_d     = RESP;
                    rdata_out_d = we_q ? '0 : a_load_data;
                    rrd_d       = we_q ? 5'd0 : rd_q;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rerr_d      = 1'b1;
                    rdata_out_d = '0;
                    rrd_d       = we_q ? 5'd0 : rd_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs, decoded from the registered state so they are glitch-free
    // and all-zero outside the states that own them.
    always_comb begin
        req_ready     = (state_q == IDLE);
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_mask      = '0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_rd       = '0;
        resp_misalign = 1'b0;
        resp_buserr   = 1'b0;
        if (state_q == ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q & ~XLEN'(NB - 1);
            mem_wdata = a_wdata_sh;
            mem_mask  = a_mask;
        end
        if (state_q == RESP) begin
            resp_valid    = 1'b1;
            resp_data     = rdata_out_q;
            resp_rd       = rrd_q;
            resp_misalign = rmis_q;
            resp_buserr   = rerr_q;
        end
    end

endmodule

// File: tb/tb_lsu_multicycle.sv
module tb_lsu_multicycle;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // XLEN=32 instance
    logic        req_valid = 0, req_we = 0, mem_ack = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic [4:0]  req_rd = 0;
    logic        req_ready, mem_req, mem_we, resp_valid, resp_misalign, resp_buserr;
    logic [31:0] mem_addr, mem_wdata, resp_data;
    logic [3:0]  mem_mask;
    logic [4:0]  resp_rd;

    // XLEN=64 instance
    logic        d_req_valid = 0, d_req_we = 0, d_mem_ack = 0;
    logic [2:0]  d_req_funct3 = 0;
    logic [63:0] d_req_addr = 0, d_req_wdata = 0, d_mem_rdata = 0;
    logic [4:0]  d_req_rd = 0;
    logic        d_req_ready, d_mem_req, d_mem_we, d_resp_valid, d_resp_misalign, d_resp_buserr;
    logic [63:0] d_mem_addr, d_mem_wdata, d_resp_data;
    logic [7:0]  d_mem_mask;
    logic [4:0]  d_resp_rd;

    lsu_multicycle #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_misalign(resp_misalign), .resp_buserr(resp_buserr)
    );

    lsu_multicycle #(.XLEN(64), .TIMEOUT(4)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
        .req_funct3(d_req_funct3), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
        .req_rd(d_req_rd),
        .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
        .mem_wdata(d_mem_wdata), .mem_mask(d_mem_mask), .mem_ack(d_mem_ack),
        .mem_rdata(d_mem_rdata),
        .resp_valid(d_resp_valid), .resp_data(d_resp_data), .resp_rd(d_resp_rd),
        .resp_misalign(d_resp_misalign), .resp_buserr(d_resp_buserr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are checked and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mask", 64'(mem_mask), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst64_ready", 64'(d_req_ready), 64'd1);
        reset = 0;

        // LB from 0x103, ack on third ACCESS cycle
        tick();
        req32(0, 3'b000, 32'h103, 32'h0, 5'd9);                 // cycle T
        tick(); req_valid = 0;                                   // T+1
        check("lb_mem_req", 64'(mem_req), 64'd1);
        check("lb_mask", 64'(mem_mask), 64'h8);
        check("lb_addr", 64'(mem_addr), 64'h100);
        check("lb_we", 64'(mem_we), 64'd0);
        check("lb_ready_busy", 64'(req_ready), 64'd0);
        tick();                                                  // T+2
        check("lb_mem_req_hold", 64'(mem_req), 64'd1);
        tick(); mem_ack = 1; mem_rdata = 32'h80FF_1234;          // T+3
        tick(); mem_ack = 0;                                     // T+4
        check("lb_resp_valid", 64'(resp_valid), 64'd1);
        check("lb_resp_data", 64'(resp_data), 64'hFFFF_FF80);
        check("lb_resp_rd", 64'(resp_rd), 64'd9);
        check("lb_mem_req_off", 64'(mem_req), 64'd0);
        tick();                                                  // T+5
        check("lb_resp_pulse", 64'(resp_valid), 64'd0);
        check("lb_ready_again", 64'(req_ready), 64'd1);

        // SH to 0x202, immediate ack
        req32(1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd3);
        tick(); req_valid = 0; mem_ack = 1;                      // T+1
        check("sh_we", 64'(mem_we), 64'd1);
        check("sh_mask", 64'(mem_mask), 64'hC);
        check("sh_wdata", 64'(mem_wdata), 64'hBEEF_0000);
        check("sh_addr", 64'(mem_addr), 64'h200);
        tick(); mem_ack = 0;                                     // T+2
        check("sh_resp_valid", 64'(resp_valid), 64'd1);
        check("sh_resp_data", 64'(resp_data), 64'd0);
        check("sh_resp_rd", 64'(resp_rd), 64'd0);
        tick();

        // LW to 0x205: misaligned
        req32(0, 3'b010, 32'h205, 32'h0, 5'd7);
        tick(); req_valid = 0;                                   // T+1
        check("lw_mis_mem_req", 64'(mem_req), 64'd0);
        check("lw_mis_valid", 64'(resp_valid), 64'd1);
        check("lw_mis_flag", 64'(resp_misalign), 64'd1);
        check("lw_mis_data", 64'(resp_data), 64'd0);
        tick();                                                  // T+2
        check("lw_mis_ready", 64'(req_ready), 64'd1);
        check("lw_mis_mem_req2", 64'(mem_req), 64'd0);

        // Illegal funct3 on XLEN=32 (LD)
        req32(0, 3'b011, 32'h208, 32'h0, 5'd4);
        tick(); req_valid = 0;
        check("ld32_illegal", 64'(resp_misalign), 64'd1);
        check("ld32_no_mem", 64'(mem_req), 64'd0);
        tick();

        // LHU from 0x10 with no ack: timeout after 4 ACCESS cycles
        req32(0, 3'b101, 32'h10, 32'h0, 5'd12);
        for (int i = 0; i < 4; i++) begin
            tick(); req_valid = 0;
            check("to_mem_req", 64'(mem_req), 64'd1);
            check("to_no_resp", 64'(resp_valid), 64'd0);
        end
        tick();
        check("to_resp_valid", 64'(resp_valid), 64'd1);
        check("to_buserr", 64'(resp_buserr), 64'd1);
        check("to_data", 64'(resp_data), 64'd0);
        check("to_mem_req_off", 64'(mem_req), 64'd0);
        tick();

        // Same, with ack on the 4th ACCESS cycle
        req32(0, 3'b101, 32'h10, 32'h0, 5'd12);
        tick(); req_valid = 0;
        tick(); tick();
        tick(); mem_ack = 1; mem_rdata = 32'h1234_8001;
        check("ack4_mem_req", 64'(mem_req), 64'd1);
        tick(); mem_ack = 0;
        check("ack4_valid", 64'(resp_valid), 64'd1);
        check("ack4_buserr", 64'(resp_buserr), 64'd0);
        check("ack4_data", 64'(resp_data), 64'h0000_8001);
        check("ack4_rd", 64'(resp_rd), 64'd12);
        tick();

        // Reset mid-ACCESS, then a late ack
        req32(0, 3'b010, 32'h40, 32'h0, 5'd5);
        tick(); req_valid = 0;
        check("rma_mem_req", 64'(mem_req), 64'd1);
        reset = 1;
        tick(); reset = 0;
        check("rma_mem_req_off", 64'(mem_req), 64'd0);
        check("rma_ready", 64'(req_ready), 64'd1);
        check("rma_no_resp", 64'(resp_valid), 64'd0);
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        tick(); mem_ack = 0;
        check("late_ack_no_resp", 64'(resp_valid), 64'd0);
        check("late_ack_ready", 64'(req_ready), 64'd1);
        check("late_ack_no_req", 64'(mem_req), 64'd0);

        // XLEN=64: LD from 0x8
        d_req_valid = 1; d_req_we = 0; d_req_funct3 = 3'b011;
        d_req_addr = 64'h8; d_req_rd = 5'd20;
        tick(); d_req_valid = 0; d_mem_ack = 1; d_mem_rdata = 64'h8000_0000_0000_0001;
        check("ld64_mask", 64'(d_mem_mask), 64'hFF);
        check("ld64_addr", d_mem_addr, 64'h8);
        tick(); d_mem_ack = 0;
        check("ld64_valid", 64'(d_resp_valid), 64'd1);
        check("ld64_data", d_resp_data, 64'h8000_0000_0000_0001);
        check("ld64_rd", 64'(d_resp_rd), 64'd20);
        tick();

        // XLEN=64: LWU from 0xC
        d_req_valid = 1; d_req_funct3 = 3'b110; d_req_addr = 64'hC; d_req_rd = 5'd21;
        tick(); d_req_valid = 0; d_mem_ack = 1; d_mem_rdata = 64'h8000_0000_0000_0000;
        check("lwu64_mask", 64'(d_mem_mask), 64'hF0);
        check("lwu64_addr", d_mem_addr, 64'h8);
        tick(); d_mem_ack = 0;
        check("lwu64_valid", 64'(d_resp_valid), 64'd1);
        check("lwu64_data", d_resp_data, 64'h0000_0000_8000_0000);
        check("lwu64_misalign", 64'(d_resp_misalign), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_multicycle.md
Name: lsu_multicycle

Overview:
Parametrised multi-cycle load/store unit, the successor to the single-cycle LSU/data-memory path in the RV32 datapath. It accepts one load/store request from the core over a valid/ready handshake and drives a word-addressed memory port with byte-lane masks. It waits a variable number of cycles for memory acknowledge, aligns and sign/zero-extends load data, and returns one response with destination register and error flags. It adds misalignment detection and a bus-timeout watchdog, which the single-cycle path lacks.

Parameters:
XLEN, 32, data/address width; legal values 32 and 64; byte lanes NB = XLEN/8.
TIMEOUT, 16, maximum cycles waiting for mem_ack before a bus error; must be 1..255.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  core presents a request.
req_ready  out  1  LSU idle and able to accept a request.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
req_addr  in  XLEN  byte address (rs1 + imm).
req_wdata  in  XLEN  store data (rs2), right-justified.
req_rd  in  5  load destination register.
mem_req  out  1  memory access strobe; held high until mem_ack.
mem_we  out  1  write enable.
mem_addr  out  XLEN  address with the low log2(NB) bits forced to zero.
mem_wdata  out  XLEN  lane-shifted store data.
mem_mask  out  NB  byte-lane enable.
mem_ack  in  1  memory completes the access; mem_rdata is valid in the same cycle.
mem_rdata  in  XLEN  aligned read word.
resp_valid  out  1  one-cycle response pulse.
resp_data  out  XLEN  extended load result; 0 for stores and errors.
resp_rd  out  5  latched req_rd; 0 for stores.
resp_misalign  out  1  access was misaligned; no memory access was made.
resp_buserr  out  1  TIMEOUT expired.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state is IDLE. All outputs are 0 except req_ready=1. The timeout counter is cleared. Reset in any state aborts the access in the same edge, and mem_req drops on the next cycle.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, latch we, funct3, addr, wdata, rd.
  - Misaligned access goes to RESP with misalign=1. Misaligned means: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0.
  - Illegal funct3 (111, or 011/110 when XLEN=32) is reported as misalign=1.
  - Any other request goes to ACCESS and clears the counter.
- ACCESS: mem_req=1, req_ready=0. mem_addr, mem_we, mem_mask and mem_wdata stay stable for the whole state.
  - Mask: byte = 1<<off; half = 2'b11<<off; word = 4'hF<<off; dword = all ones. Here off = addr[log2(NB)-1:0].
  - wdata: the low 8/16/32/64 bits shifted left by 8*off.
  - On mem_ack: for loads, extract the bytes at off and sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1). Capture the result into resp_data and go to RESP.
  - With no ack, the counter increments each cycle. When the counter reaches TIMEOUT-1 with no ack, go to RESP with buserr=1. An ack in that same cycle wins and there is no error.
- RESP: resp_valid=1 for exactly one cycle, with registered data, rd and flags. mem_req=0. Next state is IDLE.
- Latency: an aligned request accepted in cycle T sees mem_req from T+1. An ack in cycle T+1+k gives resp_valid in T+2+k. A misaligned request gives resp_valid in T+1.
- req_valid is ignored outside IDLE. No pipelining: at most one outstanding request.
- mem_ack outside ACCESS is ignored.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - state enum lsu_state_t {IDLE, ACCESS, RESP};
  - function size_bytes(funct3).
- One sub-module, lsu_align: purely combinational. It computes mask, shifted wdata, the misalign flag and the extended load data from funct3, off, wdata and rdata, parametrised by XLEN.
- The FSM and timeout counter stay in lsu_multicycle.

Test Plan:
- LB from addr 0x103, mem_rdata=0x80FF_1234, ack after 2 cycles -> mem_mask=4'b1000, mem_addr=0x100, resp_data=0xFFFF_FF80, resp_rd latched, resp_valid 1 cycle.
- SH to addr 0x202, wdata=0xDEAD_BEEF, immediate ack -> mem_we=1, mem_mask=4'b1100, mem_wdata[31:16]=0xBEEF, resp_data=0, resp_valid at T+2.
- LW to addr 0x205 -> no mem_req ever; resp_misalign=1 and resp_valid at T+1; req_ready=1 at T+2.
- LHU from 0x10, no ack, TIMEOUT=4 -> mem_req high for exactly 4 cycles, then resp_buserr=1, resp_data=0. Repeat with ack on the 4th cycle -> buserr=0, data valid.
- Reset asserted mid-ACCESS -> next cycle mem_req=0, req_ready=1, no resp_valid. A late mem_ack afterwards is ignored.
- XLEN=64: LD from 0x8 with rdata 0x8000_0000_0000_0001 -> mask 8'hFF, resp_data equal to rdata. LWU from 0xC -> resp_data=0x0000_0000_8000_0000.
